scope_trigger_capture: RTL and testbench
========================================

# scope_trigger_capture

Trigger-and-capture stage for the oscilloscope datapath. It sits directly downstream of the waveform multiplexer and consumes its clipped 12-bit signed output one sample at a time. It detects a level-crossing trigger and stores one screen-width frame of samples around the trigger point in a circular buffer. The frame is then held stable for the display renderer, which reads it by horizontal pixel address.

## Interface
Parameters:
- DEPTH, 640, samples per frame (one per horizontal pixel)
- ADDR_W, 10, width of buffer and read addresses; 2^ADDR_W ≥ DEPTH
- PRETRIG, 320, samples kept before the trigger sample; 1 ≤ PRETRIG ≤ DEPTH-2
- AUTO_TIMEOUT, 4096, samples spent waiting in auto mode before a forced trigger

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sample_in  in  12  signed sample from the multiplexer
- sample_valid  in  1  one-cycle strobe; sample_in is valid; at most one sample per clock
- trig_level  in  12  signed trigger threshold
- trig_slope  in  1  0 = rising edge, 1 = falling edge
- trig_mode  in  2  00 = auto, 01 = normal, 10 = single, 11 = treated as normal
- arm  in  1  re-arm pulse for single mode
- rd_addr  in  ADDR_W  display read address, 0 = leftmost pixel
- frame_ack  in  1  pulse from the display: frame consumed
- rd_data  out  12  signed frame sample, registered
- frame_ready  out  1  high while a complete frame is held
- trig_pulse  out  1  one-cycle pulse when a trigger (real or forced) is accepted
- frame_forced  out  1  the held frame came from an auto timeout
- state_o  out  3  current FSM state encoding, for debug

## Operation
FSM states and transitions:
- IDLE (0): nothing is written.
  - Goes to PRE_FILL if trig_mode ≠ single.
  - Goes to PRE_FILL on arm in single mode.
- PRE_FILL (1): each valid sample is written at wr_ptr, and wr_ptr then increments with wrap DEPTH-1→0. A fill count increments with each sample. Goes to WAIT_TRIG once PRETRIG samples have been written.
- WAIT_TRIG (2): writes continue.
  - Rising trigger: prev < trig_level and cur ≥ trig_level.
  - Falling trigger: prev > trig_level and cur ≤ trig_level.
  - Comparisons are signed 12-bit. prev is the previous valid sample and is updated in every writing state.
  - In auto mode, a timeout counter counts valid samples, reset on entry. When it reaches AUTO_TIMEOUT, the current sample is treated as the trigger sample and frame_forced is set.
  - On trigger: the trigger sample is written, trig_ptr = its address, start_ptr = (trig_ptr − PRETRIG) mod DEPTH, trig_pulse is raised, and the FSM goes to POST_FILL.
- POST_FILL (3): writes DEPTH−PRETRIG−1 further samples, then goes to HOLD.
- HOLD (4): no writes; frame_ready = 1. On frame_ack:
  - single mode → IDLE;
  - other modes → PRE_FILL, with fill and timeout counters cleared and frame_forced cleared.

Read path:
- rd_data <= mem[(start_ptr + rd_addr) mod DEPTH]. The wrap is computed by subtracting DEPTH when the sum is ≥ DEPTH.
- rd_addr ≥ DEPTH → rd_data <= 0.
- Reads are allowed in every state. Contents are defined only while frame_ready = 1.

## Timing
- Reset values:
  - state IDLE; wr_ptr, start_ptr, counters and prev all 0.
  - rd_data 0, frame_ready 0, trig_pulse 0, frame_forced 0.
  - Memory contents are not cleared.
- Write latency: a sample is written in the same clock edge that samples sample_valid.
- Trigger latency: trig_pulse is high in the cycle after the trigger sample's valid edge. state_o = 3 in that same cycle.
- frame_ready rises in the cycle after the final POST_FILL sample is written. It falls in the cycle after frame_ack.
- Read latency: one clock, rd_addr → rd_data.
- frame_ack outside HOLD is ignored. arm outside IDLE is ignored.
- sample_valid in the same cycle as a HOLD→PRE_FILL transition: that sample is discarded, not written.
- trig_level, trig_slope and trig_mode changes take effect on the next valid sample. Mode is re-sampled in IDLE and at HOLD exit.
- A trigger condition in PRE_FILL is ignored.
- If a real trigger and the auto timeout coincide, the real trigger wins and frame_forced = 0.
- Reset mid-capture: asynchronous return to IDLE with all outputs at reset values. The first frame after reset is a full PRE_FILL.
- Sample gaps (sample_valid low) stall all counters; no timeouts are counted in clock cycles.

## Test plan
Bench uses DEPTH=16, PRETRIG=4, AUTO_TIMEOUT=8.
- Normal, rising, level 0, ramp −10,−9,…: trigger on sample 0 → trig_pulse once; frame_ready after sample 11; rd_addr 0..15 reads −4..11.
- Falling slope, level 100, samples 200,150,100,50…: trigger on 100 → rd_addr 4 = 100, rd_addr 3 = 150.
- Auto mode, constant input 5, level 0: after 4 pre-fill plus 8 waiting samples → forced trigger, frame_forced = 1, all rd_data = 5.
- Single mode: after frame_ack → IDLE, no writes, frame_ready 0. After an arm pulse, capture repeats.
- Wrap: start_ptr ≠ 0 after several frames; rd_addr 15 returns the last sample; rd_addr 20 returns 0.
- Reset pulled low during POST_FILL → frame_ready 0, state_o 0, immediately. After release, the next frame shows a correct pre-trigger history.

Source files
------------

// File: rtl/scope_trigger_capture.sv
// Oscilloscope trigger-and-capture stage: level-crossing trigger, circular frame
// buffer with pre-trigger history, held for the display renderer to read by pixel.
module scope_trigger_capture #(
  parameter int unsigned DEPTH        = 640,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned PRETRIG      = 320,
  parameter int unsigned AUTO_TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [11:0]       sample_in,
  input  logic                     sample_valid,
  input  logic signed [11:0]       trig_level,
  input  logic                     trig_slope,
  input  logic [1:0]               trig_mode,
  input  logic                     arm,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic                     frame_ack,
  output logic signed [11:0]       rd_data,
  output logic                     frame_ready,
  output logic                     trig_pulse,
  output logic                     frame_forced,
  output logic [2:0]               state_o
);

  localparam int unsigned SW     = 12;
  localparam int unsigned AW1    = ADDR_W + 1;
  localparam int unsigned TO_W   = $clog2(AUTO_TIMEOUT + 1);
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRETRIG - 2);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] WRAP_OFS  = ADDR_W'(DEPTH - PRETRIG);
  localparam logic [AW1-1:0]    DEPTH_X   = AW1'(DEPTH);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);
  localparam logic [1:0]        MODE_AUTO   = 2'b00;
  localparam logic [1:0]        MODE_SINGLE = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE_FILL  = 3'd1,
    WAIT_TRIG = 3'd2,
    POST_FILL = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0]    wr_ptr, start_ptr, fill_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic signed [SW-1:0] prev;
  logic [1:0]           mode_q;
  logic signed [SW-1:0] mem [DEPTH];

  logic                 wr_en, trig_real, trig_forced, trig_fire, hold_exit, mode_load;
  logic                 hit_rise, hit_fall, rd_oob;
  logic [ADDR_W-1:0]    wr_ptr_inc, trig_start, rd_idx;
  logic [AW1-1:0]       rd_sum;

  assign hit_rise   = (prev < trig_level) && (sample_in >= trig_level);
  assign hit_fall   = (prev > trig_level) && (sample_in <= trig_level);
  assign wr_ptr_inc = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_W'(1);
  assign trig_start = (wr_ptr >= PRE_OFS) ? wr_ptr - PRE_OFS : wr_ptr + WRAP_OFS;
  assign state_o    = state;

  // Next-state and per-cycle strobes
  always_comb begin
    state_next  = state;
    wr_en       = 1'b0;
    trig_real   = 1'b0;
    trig_forced = 1'b0;
    trig_fire   = 1'b0;
    hold_exit   = 1'b0;
    mode_load   = 1'b0;
    case (state)
      IDLE: begin
        if ((trig_mode != MODE_SINGLE) || arm) begin
          state_next = PRE_FILL;
          mode_load  = 1'b1;
        end
      end
      PRE_FILL: begin
        wr_en = sample_valid;
        if (sample_valid && (fill_cnt == PRE_LAST)) state_next = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        wr_en       = sample_valid;
        trig_real   = sample_valid && (trig_slope ? hit_fall : hit_rise);
        // A real crossing on the timeout sample takes precedence over the forced one
        trig_forced = sample_valid && (mode_q == MODE_AUTO) && (to_cnt == TO_LAST) && !trig_real;
        trig_fire   = trig_real || trig_forced;
        if (trig_fire) state_next = POST_FILL;
      end
      POST_FILL: begin
        wr_en = sample_valid;
        if (sample_valid && (fill_cnt == POST_LAST)) state_next = HOLD;
      end
      HOLD: begin
        if (frame_ack) begin
          hold_exit = 1'b1;
          mode_load = 1'b1;
          if (trig_mode == MODE_SINGLE) state_next = IDLE;
          else                          state_next = PRE_FILL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read address rotated by the frame start, with modulo-DEPTH wrap
  always_comb begin
    rd_sum = {1'b0, start_ptr} + {1'b0, rd_addr};
    rd_idx = rd_sum[ADDR_W-1:0];
    if (rd_sum >= DEPTH_X) rd_idx = ADDR_W'(rd_sum - DEPTH_X);
    rd_oob = ({1'b0, rd_addr} >= DEPTH_X);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      start_ptr    <= '0;
      fill_cnt     <= '0;
      to_cnt       <= '0;
      prev         <= '0;
      mode_q       <= MODE_AUTO;
      rd_data      <= '0;
      frame_ready  <= 1'b0;
      trig_pulse   <= 1'b0;
      frame_forced <= 1'b0;
    end else begin
      state <= state_next;
      if (mode_load) mode_q <= trig_mode;
      if (wr_en) begin
        wr_ptr <= wr_ptr_inc;
        prev   <= sample_in;
      end
      // Fill count restarts on every state change; timeout only runs while waiting
      if (state_next != state) fill_cnt <= '0;
      else if (wr_en)          fill_cnt <= fill_cnt + ADDR_W'(1);
      if ((state != WAIT_TRIG) || (state_next != WAIT_TRIG)) to_cnt <= '0;
      else if (wr_en)                                         to_cnt <= to_cnt + TO_W'(1);
      if (trig_fire) start_ptr <= trig_start;
      trig_pulse  <= trig_fire;
      frame_ready <= (state_next == HOLD);
      if (trig_fire)      frame_forced <= trig_forced;
      else if (hold_exit) frame_forced <= 1'b0;
      rd_data <= rd_oob ? '0 : mem[MEM_AW'(rd_idx)];
    end
  end

  // Sample buffer; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[MEM_AW'(wr_ptr)] <= sample_in;
  end

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Self-checking bench for scope_trigger_capture: scripted captures in each trigger
// mode, frame readback through a table and an expected-value queue.
module tb_scope_trigger_capture;

  logic               clk, rst_n;
  logic signed [11:0] sample_in, trig_level, rd_data;
  logic               sample_valid, trig_slope, arm, frame_ack;
  logic [1:0]         trig_mode;
  logic [4:0]         rd_addr;
  logic               frame_ready, trig_pulse, frame_forced;
  logic [2:0]         state_o;

  scope_trigger_capture #(
    .DEPTH(16), .ADDR_W(5), .PRETRIG(4), .AUTO_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .trig_level(trig_level), .trig_slope(trig_slope), .trig_mode(trig_mode),
    .arm(arm), .rd_addr(rd_addr), .frame_ack(frame_ack), .rd_data(rd_data),
    .frame_ready(frame_ready), .trig_pulse(trig_pulse), .frame_forced(frame_forced),
    .state_o(state_o)
  );

  typedef struct {
    logic [4:0] addr;
    int         exp;
  } rd_vec_t;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int sent[$];
  int exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (trig_pulse) pulses++;
  endtask

  task automatic send(input int v, input bit rec);
    sample_in    = 12'(v);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    if (rec) sent.push_back(v);
  endtask

  task automatic ack_with_sample(input int v);
    frame_ack    = 1'b1;
    sample_in    = 12'(v);
    sample_valid = 1'b1;
    tick();
    frame_ack    = 1'b0;
    sample_valid = 1'b0;
  endtask

  // Frame readback: pixel i must hold the sample PRETRIG before the trigger, plus i
  task automatic read_frame(input string tag, input int ti);
    rd_vec_t tbl[18];
    for (int i = 0; i < 16; i++) begin
      tbl[i].addr = 5'(i);
      tbl[i].exp  = sent[ti - 4 + i];
    end
    tbl[16].addr = 5'd20; tbl[16].exp = 0;
    tbl[17].addr = 5'd4;  tbl[17].exp = sent[ti];
    for (int i = 0; i < 18; i++) begin
      rd_addr = tbl[i].addr;
      exp_q.push_back(tbl[i].exp);
      tick();
      check($sformatf("%s rd[%0d]", tag, tbl[i].addr), 32'(rd_data), exp_q.pop_front());
    end
  endtask

  initial begin
    rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0; trig_level = '0;
    trig_slope = 1'b0; trig_mode = 2'b01; arm = 1'b0; rd_addr = '0; frame_ack = 1'b0;
    repeat (3) tick();
    check("reset state", 32'(state_o), 0);
    check("reset frame_ready", 32'(frame_ready), 0);
    check("reset trig_pulse", 32'(trig_pulse), 0);
    check("reset frame_forced", 32'(frame_forced), 0);
    check("reset rd_data", 32'(rd_data), 0);

    // Normal mode, rising through 0 on a ramp
    rst_n = 1'b1;
    tick();
    check("norm enter prefill", 32'(state_o), 1);
    sent.delete(); pulses = 0;
    for (int v = -10; v <= -7; v++) send(v, 1'b1);
    check("norm wait after pretrig", 32'(state_o), 2);
    for (int v = -6; v <= -1; v++) send(v, 1'b1);
    check("norm no early trig", pulses, 0);
    send(0, 1'b1);
    check("norm trig_pulse", 32'(trig_pulse), 1);
    check("norm post state", 32'(state_o), 3);
    send(1, 1'b1);
    check("norm pulse one cycle", 32'(trig_pulse), 0);
    for (int v = 2; v <= 10; v++) send(v, 1'b1);
    check("norm not ready early", 32'(frame_ready), 0);
    send(11, 1'b1);
    check("norm frame_ready", 32'(frame_ready), 1);
    check("norm hold state", 32'(state_o), 4);
    check("norm pulse count", pulses, 1);
    check("norm not forced", 32'(frame_forced), 0);
    send(99, 1'b0);
    send(98, 1'b0);
    check("norm hold stays", 32'(state_o), 4);
    read_frame("norm", 10);

    // Falling slope at 100
    trig_slope = 1'b1; trig_level = 12'sd100;
    ack_with_sample(77);
    check("ack drops frame_ready", 32'(frame_ready), 0);
    check("ack to prefill", 32'(state_o), 1);
    sent.delete(); pulses = 0;
    send(300, 1'b1); send(250, 1'b1); send(220, 1'b1); send(210, 1'b1);
    send(200, 1'b1); send(150, 1'b1); send(100, 1'b1);
    check("fall trig_pulse", 32'(trig_pulse), 1);
    for (int k = 0; k <= 10; k++) send(50 - 50 * k, 1'b1);
    check("fall frame_ready", 32'(frame_ready), 1);
    check("fall pulse count", pulses, 1);
    read_frame("fall", 6);

    // Auto mode, flat input: forced trigger on the 8th waiting sample
    trig_mode = 2'b00; trig_slope = 1'b0; trig_level = '0;
    ack_with_sample(77);
    sent.delete(); pulses = 0;
    for (int k = 0; k < 4; k++) send(5, 1'b1);
    check("auto wait state", 32'(state_o), 2);
    check("auto prefill crossing ignored", pulses, 0);
    for (int k = 0; k < 4; k++) send(5, 1'b1);
    repeat (10) tick();
    for (int k = 0; k < 3; k++) send(5, 1'b1);
    check("auto gap stalls timeout", 32'(state_o), 2);
    check("auto no pulse before timeout", pulses, 0);
    send(5, 1'b1);
    check("auto forced pulse", 32'(trig_pulse), 1);
    check("auto frame_forced", 32'(frame_forced), 1);
    for (int k = 0; k < 11; k++) send(5, 1'b1);
    check("auto frame_ready", 32'(frame_ready), 1);
    check("auto forced held", 32'(frame_forced), 1);
    read_frame("auto", 11);

    // Auto mode, real crossing on the timeout sample wins
    ack_with_sample(0);
    check("hold exit clears forced", 32'(frame_forced), 0);
    sent.delete(); pulses = 0;
    for (int k = 0; k < 11; k++) send(-5, 1'b1);
    check("coin waiting", 32'(state_o), 2);
    send(3, 1'b1);
    check("coin trig_pulse", 32'(trig_pulse), 1);
    check("coin not forced", 32'(frame_forced), 0);
    for (int k = 0; k < 11; k++) send(100 + k, 1'b1);
    check("coin frame_ready", 32'(frame_ready), 1);
    read_frame("coin", 11);

    // Single mode: idles after ack until armed
    trig_mode = 2'b10;
    ack_with_sample(0);
    check("single idle", 32'(state_o), 0);
    check("single frame_ready low", 32'(frame_ready), 0);
    pulses = 0;
    send(-100, 1'b0); send(100, 1'b0);
    repeat (4) tick();
    check("single stays idle", 32'(state_o), 0);
    check("single no pulse idle", pulses, 0);
    arm = 1'b1; tick(); arm = 1'b0;
    check("single armed", 32'(state_o), 1);
    sent.delete();
    for (int k = 0; k < 20; k++) send(2 * k - 16, 1'b1);
    check("single frame_ready", 32'(frame_ready), 1);
    check("single pulse count", pulses, 1);
    read_frame("single", 8);
    frame_ack = 1'b1; tick(); frame_ack = 1'b0;
    repeat (3) tick();
    check("single back idle", 32'(state_o), 0);
    arm = 1'b1; tick(); arm = 1'b0;
    check("single rearmed", 32'(state_o), 1);

    // Asynchronous reset during POST_FILL, then a fresh capture
    send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
    send(-1, 1'b0); send(5, 1'b0); send(6, 1'b0); send(7, 1'b0);
    check("pre-reset post state", 32'(state_o), 3);
    #2 rst_n = 1'b0;
    #1;
    check("async reset state", 32'(state_o), 0);
    check("async reset frame_ready", 32'(frame_ready), 0);
    check("async reset trig_pulse", 32'(trig_pulse), 0);
    trig_mode = 2'b01;
    tick();
    rst_n = 1'b1;
    tick();
    check("post-reset prefill", 32'(state_o), 1);
    sent.delete(); pulses = 0;
    send(10, 1'b1); send(11, 1'b1); send(12, 1'b1); send(13, 1'b1);
    send(-1, 1'b1); send(-2, 1'b1); send(20, 1'b1);
    check("post-reset trig", 32'(trig_pulse), 1);
    for (int k = 21; k <= 31; k++) send(k, 1'b1);
    check("post-reset frame_ready", 32'(frame_ready), 1);
    read_frame("rst", 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
